// File: rtl/mem_access_ctrl.sv
// Processor-to-RAM access controller: byte/half/word loads and stores
// over a word-wide synchronous RAM. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDWAIT,
        WR,
        RESP
    } state_t;

    localparam logic [3:0] LAST = 4'(RD_LAT - 1);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [3:0]  cnt;
    logic        misaligned;

    // Alignment fault detection for the incoming request
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0])
                     || (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Insert a byte or half into its little-endian lane of a word
    function automatic logic [31:0] merge(
        input logic [31:0] word,
        input logic [15:0] wd,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = word;
        if (size == 2'b00)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else if (size == 2'b01)
            r[{off[1], 4'b0000} +: 16] = wd;
        return r;
    endfunction

    // Pull a lane out of a word and zero/sign extend it
    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        if (size == 2'b00)
            r = {{24{sgn & b[7]}}, b};
        else if (size == 2'b01)
            r = {{16{sgn & h[15]}}, h};
        else
            r = word;
        return r;
    endfunction

    // Single FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_din    <= 32'h0;
            cnt        <= 4'h0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
        end else begin
            resp_valid <= 1'b0;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_we && req_size[1]) begin
                            state   <= WR;
                            mem_cs  <= 1'b1;
                            mem_we  <= 1'b1;
                            mem_din <= req_wdata;
                        end else begin
                            state  <= RD;
                            mem_cs <= 1'b1;
                            mem_oe <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= RDWAIT;
                    cnt   <= 4'h0;
                end
                RDWAIT: begin
                    if (cnt == LAST) begin
                        cnt <= 4'h0;
                        if (we_q) begin
                            state   <= WR;
                            mem_cs  <= 1'b1;
                            mem_we  <= 1'b1;
                            mem_din <= merge(mem_dout, wdata_q,
                                             size_q, off_q);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= extract(mem_dout, size_q,
                                                  off_q, signed_q);
                        end
                    end else begin
                        cnt <= cnt + 4'h1;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with RAM models and a response
// scoreboard; instances with RD_LAT=1 and RD_LAT=3.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, v3;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, wdata;

    logic        r1_ready, r1_rv, r1_err, r1_cs, r1_oe, r1_we;
    logic [31:0] r1_rdata, r1_addr, r1_din, r1_dout;
    logic        r3_ready, r3_rv, r3_err, r3_cs, r3_oe, r3_we;
    logic [31:0] r3_rdata, r3_addr, r3_din, r3_dout;

    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(r1_ready),
        .req_we(we), .req_size(size), .req_signed(sgn),
        .req_addr(addr), .req_wdata(wdata),
        .resp_valid(r1_rv), .resp_rdata(r1_rdata), .resp_err(r1_err),
        .mem_cs(r1_cs), .mem_oe(r1_oe), .mem_we(r1_we),
        .mem_addr(r1_addr), .mem_din(r1_din), .mem_dout(r1_dout)
    );

    mem_access_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(r3_ready),
        .req_we(we), .req_size(size), .req_signed(sgn),
        .req_addr(addr), .req_wdata(wdata),
        .resp_valid(r3_rv), .resp_rdata(r3_rdata), .resp_err(r3_err),
        .mem_cs(r3_cs), .mem_oe(r3_oe), .mem_we(r3_we),
        .mem_addr(r3_addr), .mem_din(r3_din), .mem_dout(r3_dout)
    );

    // RAM with a one-stage read pipeline
    always @(posedge clk) begin
        if (r1_cs && r1_we) ram1[r1_addr[7:2]] <= r1_din;
        p1 <= (r1_cs && r1_oe) ? ram1[r1_addr[7:2]] : 32'h0;
    end
    assign r1_dout = p1;

    // RAM with a three-stage read pipeline
    always @(posedge clk) begin
        if (r3_cs && r3_we) ram3[r3_addr[7:2]] <= r3_din;
        p3[0] <= (r3_cs && r3_oe) ? ram3[r3_addr[7:2]] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign r3_dout = p3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel;
    logic        o_ready, o_rv, o_err, o_cs, o_oe, o_we;
    logic [31:0] o_rdata, o_addr, o_din;
    always_comb begin
        o_ready = sel ? r3_ready : r1_ready;
        o_rv    = sel ? r3_rv    : r1_rv;
        o_err   = sel ? r3_err   : r1_err;
        o_cs    = sel ? r3_cs    : r1_cs;
        o_oe    = sel ? r3_oe    : r1_oe;
        o_we    = sel ? r3_we    : r1_we;
        o_rdata = sel ? r3_rdata : r1_rdata;
        o_addr  = sel ? r3_addr  : r1_addr;
        o_din   = sel ? r3_din   : r1_din;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          edge_n;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int n;
    int rd_cnt, wr_cnt, rd_edge, wr_edge;
    logic [31:0] rd_addr, wr_addr, wr_din;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit d3, input bit w, input logic [1:0] sz,
                         input bit s, input logic [31:0] a,
                         input logic [31:0] d);
        int k;
        @(negedge clk);
        sel = d3; we = w; size = sz; sgn = s; addr = a; wdata = d;
        if (d3) v3 = 1'b1;
        else    v1 = 1'b1;
        #1;
        k = 0;
        while (!o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!o_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        n = cyc;
        v1 = 1'b0; v3 = 1'b0;
        rd_cnt = 0; wr_cnt = 0; rd_edge = -1; wr_edge = -1;
        rd_addr = 32'hx; wr_addr = 32'hx; wr_din = 32'hx;
    endtask

    task automatic expect_resp(input logic [31:0] rd, input bit err,
                               input int lat, input bit chk);
        exp_t e;
        e.rdata = rd; e.err = err; e.edge_n = n + lat; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic run_resp(input string tag);
        exp_t e;
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (o_cs && o_oe) begin
                rd_cnt++; rd_edge = cyc + 1; rd_addr = o_addr;
            end
            if (o_cs && o_we) begin
                wr_cnt++; wr_edge = cyc + 1;
                wr_addr = o_addr; wr_din = o_din;
            end
            if (o_rv) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    check({tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_edge"}, 32'(cyc + 1), 32'(e.edge_n));
                    check({tag, "_err"}, {31'd0, o_err}, {31'd0, e.err});
                    if (e.chk) check({tag, "_rdata"}, o_rdata, e.rdata);
                end
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1; v1 = 1'b0; v3 = 1'b0; sel = 1'b0;
        we = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_rv", {31'd0, o_rv}, 32'd0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_strobes", {29'd0, o_cs, o_oe, o_we}, 32'd0);
        check("rst_addr", o_addr, 32'h0);
        check("rst_din", o_din, 32'h0);
        sel = 1'b1;
        #1;
        check("rst3_ready", {31'd0, o_ready}, 32'd1);
        check("rst3_strobes", {29'd0, o_cs, o_oe, o_we}, 32'd0);

        // word store then word load
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        expect_resp(32'h0, 0, 2, 0);
        run_resp("wst");
        check("wst_wr_edge", 32'(wr_edge), 32'(n + 1));
        check("wst_addr", wr_addr, 32'h10);
        check("wst_din", wr_din, 32'hDEADBEEF);
        check("wst_no_rd", 32'(rd_cnt), 32'd0);

        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        expect_resp(32'hDEADBEEF, 0, 3, 1);
        run_resp("wld");
        check("wld_rd_edge", 32'(rd_edge), 32'(n + 1));
        check("wld_addr", rd_addr, 32'h10);
        check("wld_no_wr", 32'(wr_cnt), 32'd0);

        // byte store read-modify-write
        issue(0, 1, 2'b10, 0, 32'h10, 32'h11223344);
        expect_resp(32'h0, 0, 2, 0);
        run_resp("pre1");
        issue(0, 1, 2'b00, 0, 32'h13, 32'h000000A5);
        expect_resp(32'h0, 0, 4, 0);
        run_resp("bst");
        check("bst_rd_edge", 32'(rd_edge), 32'(n + 1));
        check("bst_wr_edge", 32'(wr_edge), 32'(n + 3));
        check("bst_din", wr_din, 32'hA5223344);
        check("bst_addr", wr_addr, 32'h10);

        // sub-word loads
        issue(0, 1, 2'b10, 0, 32'h10, 32'h80011234);
        expect_resp(32'h0, 0, 2, 0);
        run_resp("pre2");
        issue(0, 0, 2'b01, 1, 32'h12, 32'h0);
        expect_resp(32'hFFFF8001, 0, 3, 1);
        run_resp("hld_s");
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0);
        expect_resp(32'h00008001, 0, 3, 1);
        run_resp("hld_u");
        issue(0, 0, 2'b00, 1, 32'h10, 32'h0);
        expect_resp(32'h00000034, 0, 3, 1);
        run_resp("bld0_s");
        issue(0, 0, 2'b00, 1, 32'h13, 32'h0);
        expect_resp(32'hFFFFFF80, 0, 3, 1);
        run_resp("bld3_s");
        issue(0, 0, 2'b00, 0, 32'h11, 32'h0);
        expect_resp(32'h00000012, 0, 3, 1);
        run_resp("bld1_u");

        // half store into upper lane
        issue(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF);
        expect_resp(32'h0, 0, 4, 0);
        run_resp("hst");
        check("hst_din", wr_din, 32'hBEEF1234);
        issue(0, 0, 2'b11, 0, 32'h10, 32'h0);
        expect_resp(32'hBEEF1234, 0, 3, 1);
        run_resp("wld11");

        // misaligned accesses
        issue(0, 0, 2'b10, 0, 32'h11, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        expect_resp(32'h0, 1, 1, 1);
        run_resp("mis_w");
        check("mis_w_no_cs", 32'(rd_cnt + wr_cnt), 32'd0);
`else
        expect_resp(32'hBEEF1234, 0, 3, 1);
        run_resp("mis_w");
        check("mis_w_addr", rd_addr, 32'h10);
`endif
        issue(0, 0, 2'b01, 0, 32'h13, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        expect_resp(32'h0, 1, 1, 1);
        run_resp("mis_h");
        check("mis_h_no_cs", 32'(rd_cnt + wr_cnt), 32'd0);
`else
        expect_resp(32'h0000BEEF, 0, 3, 1);
        run_resp("mis_h");
`endif

        // reset during RDWAIT aborts the load silently
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_strobes", {29'd0, o_cs, o_oe, o_we}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_rv) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        expect_resp(32'hBEEF1234, 0, 3, 1);
        run_resp("recover");

        // longer read latency
        issue(1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D);
        expect_resp(32'h0, 0, 2, 0);
        run_resp("l3_wst");
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0);
        expect_resp(32'hCAFEF00D, 0, 5, 1);
        run_resp("l3_wld");
        check("l3_rd_cnt", 32'(rd_cnt), 32'd1);
        check("l3_rd_edge", 32'(rd_edge), 32'(n + 1));
        issue(1, 1, 2'b00, 0, 32'h11, 32'h0000005A);
        expect_resp(32'h0, 0, 6, 0);
        run_resp("l3_bst");
        check("l3_bst_din", wr_din, 32'hCAFE5A0D);
        check("l3_bst_wr_edge", 32'(wr_edge), 32'(n + 5));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: RD_LAT, default 1, cycles from the RAM read-strobe cycle to the cycle in which mem_dout is captured; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  processor request present.
REQ-005 SHALL have port: req_ready  output  1  controller idle; request accepted when req_valid & req_ready at a clk edge.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port: req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-justified for sub-word.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  output  32  load result, valid with resp_valid, held until next response.
REQ-013 SHALL have port: resp_err  output  1  misaligned-access flag, valid with resp_valid.
REQ-014 SHALL have ports: mem_cs, mem_oe, mem_we  output  1 each  strobes to word-wide sync RAM.
REQ-015 SHALL have ports: mem_addr  output  32, mem_din  output  32, mem_dout  input  32  RAM address (word-aligned, addr[1:0]=00), write data, registered read data (valid the cycle after cs&oe sampled).

Function
REQ-016 SHALL implement FSM states IDLE, RD, RDWAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL latch req_* at acceptance; req_* ignored in all other states.
REQ-018 SHALL on acceptance go: word store -> WR; load or sub-word store -> RD.
REQ-019 SHALL in RD drive cs=oe=1, we=0 for exactly one cycle, then enter RDWAIT.
REQ-020 SHALL remain RD_LAT cycles in RDWAIT (internal counter), capturing mem_dout at the end of the last; then sub-word store -> WR, load -> RESP.
REQ-021 SHALL in WR drive cs=we=1, oe=0 for one cycle, mem_din = merged word, then enter RESP.
REQ-022 SHALL merge sub-word stores little-endian: byte lane k = addr[1:0] at bits 8k+7:8k, half lane = addr[1] at bits 16*addr[1]+15:16*addr[1]; other bytes from captured word.
REQ-023 SHALL extract loads from the same lanes, zero-extend, or sign-extend if req_signed; word loads return the captured word.
REQ-024 SHALL in RESP assert resp_valid for one cycle, then return to IDLE.
REQ-025 SHALL give latency from acceptance edge N: word store resp at N+2; load resp at N+2+RD_LAT; sub-word store resp at N+3+RD_LAT.
REQ-026 SHALL drive cs/oe/we=0 in IDLE, RDWAIT, RESP; mem_addr/mem_din don't-care when cs=0.

Reset
REQ-027 SHALL on rst at any edge, including mid-operation, go to IDLE with no resp_valid for the aborted request.
REQ-028 SHALL reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_cs=mem_oe=mem_we=0, mem_addr=0, mem_din=0, counter=0.

Configuration
REQ-029 SHALL, with MEM_ALIGN_CHECK_EN defined, send a misaligned request (half with addr[0]=1, word with addr[1:0]!=0) IDLE->RESP with no RAM strobe, resp_err=1, resp_rdata=0, resp at N+1.
REQ-030 SHALL, without MEM_ALIGN_CHECK_EN, tie resp_err to 0, ignore addr[1:0] for words and addr[0] for halves.

Verification
REQ-031 SHALL cover: word store 0xDEADBEEF @0x10 accepted at N -> cs&we at N+1, mem_addr 0x10, resp_valid at N+2; word load @0x10 -> resp_rdata 0xDEADBEEF at N+3.
REQ-032 SHALL cover: RAM word 0x11223344 @0x10, byte store 0xA5 @0x13 -> RD at N+1, WR at N+3 with mem_din 0xA5223344, resp at N+4.
REQ-033 SHALL cover: RAM 0x80011234 @0x10, signed half load @0x12 -> 0xFFFF8001; unsigned -> 0x00008001; signed byte load @0x10 -> 0x00000034.
REQ-034 SHALL cover: RD_LAT=3, word load accepted at N -> resp_valid at N+5, single cs&oe cycle at N+1.
REQ-035 SHALL cover: rst asserted during RDWAIT -> next cycle strobes 0, req_ready=1, no resp_valid ever for that request.
REQ-036 SHALL cover: MEM_ALIGN_CHECK_EN, word load @0x11 -> resp_valid & resp_err=1 at N+1, mem_cs never asserted; without macro -> reads word @0x10.
